// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receive path: register addresses and the
// Code-B character table used by the receiver and the transmitter-side checkers.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIG0      = 4'h1;
  localparam logic [3:0] ADDR_DIG1      = 4'h2;
  localparam logic [3:0] ADDR_DIG2      = 4'h3;
  localparam logic [3:0] ADDR_DIG3      = 4'h4;
  localparam logic [3:0] ADDR_DIG4      = 4'h5;
  localparam logic [3:0] ADDR_DIG5      = 4'h6;
  localparam logic [3:0] ADDR_DIG6      = 4'h7;
  localparam logic [3:0] ADDR_DIG7      = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int FRAME_BITS = 16;

  // Active-high segments, bit 0 = A ... bit 6 = G.
  function automatic logic [6:0] code_b_segments(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h40;
      4'hB:    seg = 7'h79;
      4'hC:    seg = 7'h76;
      4'hD:    seg = 7'h38;
      4'hE:    seg = 7'h73;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/max7219_receiver_if.sv
// Serial display link between a MAX7219-style transmitter (master) and the
// receiver (slave); spi_dout is the daisy-chain return.
interface max7219_receiver_if;
  logic spi_clk;
  logic spi_din;
  logic spi_load;
  logic spi_dout;

  modport master (output spi_clk, output spi_din, output spi_load, input spi_dout);
  modport slave  (input spi_clk, input spi_din, input spi_load, output spi_dout);
endinterface

// File: rtl/max7219_spi_sampler.sv
// Oversamples the asynchronous serial link in the clk domain, shifts frames in
// and produces one-clk commit / error strobes with the latched address and data.
module max7219_spi_sampler
  import max7219_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_din,
  input  logic       spi_load,
  output logic       spi_dout,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data
);

  logic [2:0]  r_clk_sync;
  logic [2:0]  r_load_sync;
  logic [1:0]  r_din_sync;
  logic [15:0] r_shreg;
  logic [4:0]  r_bcnt;
  logic        r_dout;
  logic        r_frame_valid;
  logic        r_frame_err;
  logic [3:0]  r_frame_addr;
  logic [7:0]  r_frame_data;

  logic w_clk_rise;
  logic w_load_rise;

  assign w_clk_rise  = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_load_rise = r_load_sync[1] & ~r_load_sync[2];

  // A load rise is tested first, so a clock edge landing in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync    <= '0;
      r_load_sync   <= '0;
      r_din_sync    <= '0;
      r_shreg       <= '0;
      r_bcnt        <= '0;
      r_dout        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_addr  <= '0;
      r_frame_data  <= '0;
    end else begin
      r_clk_sync    <= {r_clk_sync[1:0], spi_clk};
      r_load_sync   <= {r_load_sync[1:0], spi_load};
      r_din_sync    <= {r_din_sync[0], spi_din};
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_load_rise) begin
        if (r_bcnt >= 5'(FRAME_BITS)) begin
          r_frame_addr  <= r_shreg[11:8];
          r_frame_data  <= r_shreg[7:0];
          r_frame_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
        r_bcnt <= '0;
      end else if (w_clk_rise && !r_load_sync[1]) begin
        r_shreg <= {r_shreg[14:0], r_din_sync[1]};
        r_dout  <= r_shreg[15];
        if (r_bcnt != 5'd31) r_bcnt <= r_bcnt + 5'd1;
      end
    end
  end

  assign spi_dout    = r_dout;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign frame_addr  = r_frame_addr;
  assign frame_data  = r_frame_data;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 receive end: register file, scan/PWM timing and the registered
// active-low digit/segment drivers, fed by the serial sampler.
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int PHASE_DIV = 32
) (
  input  logic                clk,
  input  logic                reset,
  max7219_receiver_if.slave   spi,
  output logic [DIGITS-1:0]   dig_n,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic                frame_valid,
  output logic [3:0]          frame_addr,
  output logic [7:0]          frame_data,
  output logic                frame_err
);

  localparam int PW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PHASE_DIV - 1);

  logic       w_frame_valid;
  logic [3:0] w_frame_addr;
  logic [7:0] w_frame_data;

  max7219_spi_sampler u_sampler (
    .clk         (clk),
    .reset       (reset),
    .spi_clk     (spi.spi_clk),
    .spi_din     (spi.spi_din),
    .spi_load    (spi.spi_load),
    .spi_dout    (spi.spi_dout),
    .frame_valid (w_frame_valid),
    .frame_err   (frame_err),
    .frame_addr  (w_frame_addr),
    .frame_data  (w_frame_data)
  );

  assign frame_valid = w_frame_valid;
  assign frame_addr  = w_frame_addr;
  assign frame_data  = w_frame_data;

  logic [7:0] r_digit [8];
  logic [7:0] r_decode;
  logic [3:0] r_intensity;
  logic [2:0] r_scan_limit;
  logic       r_shutdown_n;
  logic       r_test;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_digit[i] <= '0;
      r_decode     <= '0;
      r_intensity  <= '0;
      r_scan_limit <= '0;
      r_shutdown_n <= 1'b0;
      r_test       <= 1'b0;
    end else if (w_frame_valid) begin
      case (w_frame_addr)
        ADDR_NOOP: ;
        ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3,
        ADDR_DIG4, ADDR_DIG5, ADDR_DIG6, ADDR_DIG7:
          r_digit[w_frame_addr[2:0] - 3'd1] <= w_frame_data;
        ADDR_DECODE:    r_decode     <= w_frame_data;
        ADDR_INTENSITY: r_intensity  <= w_frame_data[3:0];
        ADDR_SCANLIM:   r_scan_limit <= w_frame_data[2:0];
        ADDR_SHUTDOWN:  r_shutdown_n <= w_frame_data[0];
        ADDR_TEST:      r_test       <= w_frame_data[0];
        default: ;
      endcase
    end
  end

  logic [PW-1:0] r_presc;
  logic [4:0]    r_phase;
  logic [2:0]    r_index;
  logic [2:0]    w_limit;

  assign w_limit = r_test ? 3'd7 : r_scan_limit;

  // The limit is only consulted at a slot advance, so a lowered limit never cuts a slot short.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_phase <= '0;
      r_index <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_phase <= r_phase + 5'd1;
      if (r_phase == 5'd31) r_index <= (r_index >= w_limit) ? 3'd0 : r_index + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  logic [7:0] w_data;
  logic       w_lit;
  logic [6:0] w_seg_on;
  logic       w_dp_on;

  assign w_data = r_digit[r_index];
  assign w_lit  = (r_shutdown_n | r_test)
                & ({1'b0, r_index} < 4'(DIGITS))
                & (r_test ? (r_phase != 5'd31) : (r_phase < {r_intensity, 1'b1}));

  always_comb begin
    w_seg_on = '0;
    if (r_test)                w_seg_on = 7'h7F;
    else if (r_decode[r_index]) w_seg_on = code_b_segments(w_data[3:0]);
    else w_seg_on = {w_data[0], w_data[1], w_data[2], w_data[3], w_data[4], w_data[5], w_data[6]};
  end

  assign w_dp_on = r_test | w_data[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_n <= '1;
      seg_n <= '1;
      dp_n  <= 1'b1;
    end else begin
      dig_n <= w_lit ? ~(DIGITS'(1) << r_index) : '1;
      seg_n <= w_lit ? ~w_seg_on : '1;
      dp_n  <= w_lit ? ~w_dp_on : 1'b1;
    end
  end

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver: serial frames in, committed frames and
// scanned display windows compared against hand-computed values.
module tb_max7219_receiver;

  localparam int DIGITS    = 6;
  localparam int PHASE_DIV = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIGITS-1:0] dig_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic              frame_valid;
  logic [3:0]        frame_addr;
  logic [7:0]        frame_data;
  logic              frame_err;

  max7219_receiver_if spi();

  max7219_receiver #(.DIGITS(DIGITS), .PHASE_DIV(PHASE_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi),
    .dig_n       (dig_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_valid (frame_valid),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [31:0] dout_hist;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      spi.spi_din = val[i];
      repeat (4) @(negedge clk);
      spi.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      dout_hist = {dout_hist[30:0], spi.spi_dout};
      spi.spi_clk = 1'b0;
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    spi.spi_load = 1'b1;
    repeat (8) @(negedge clk);
    spi.spi_load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f);
    send_bits({16'h0, f}, 16);
    pulse_load();
  endtask

  task automatic wait_dig(input int b, input logic lvl, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (dig_n[b] === lvl) ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dig_n"},  32'(dig_n), 32'h3F);
    check({tag, " seg_n"},  32'(seg_n), 32'h7F);
    check({tag, " dp_n"},   32'(dp_n), 32'h1);
    check({tag, " valid"},  32'(frame_valid), 32'h0);
    check({tag, " err"},    32'(frame_err), 32'h0);
    check({tag, " addr"},   32'(frame_addr), 32'h0);
    check({tag, " data"},   32'(frame_data), 32'h0);
    check({tag, " dout"},   32'(spi.spi_dout), 32'h0);
  endtask

  // scoreboard for display windows: expected lit counts and segment patterns per digit
  int         exp_lit [DIGITS];
  logic [6:0] exp_seg [DIGITS];
  logic       exp_dp  [DIGITS];
  int         lit_cnt [DIGITS];
  int         dark_cnt;
  int         seg_bad;

  task automatic check_window(input string tag, input int cycles, input int exp_dark);
    int hit;
    for (int d = 0; d < DIGITS; d++) lit_cnt[d] = 0;
    dark_cnt = 0;
    seg_bad  = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (dig_n === '1) begin
        dark_cnt++;
        if (seg_n !== 7'h7F || dp_n !== 1'b1) seg_bad++;
      end else begin
        hit = 0;
        for (int d = 0; d < DIGITS; d++) begin
          if (dig_n[d] === 1'b0) begin
            hit++;
            lit_cnt[d]++;
            if (seg_n !== exp_seg[d] || dp_n !== exp_dp[d]) seg_bad++;
          end
        end
        if (hit != 1) seg_bad++;
      end
    end
    for (int d = 0; d < DIGITS; d++)
      check($sformatf("%s lit%0d", tag, d), 32'(lit_cnt[d]), 32'(exp_lit[d]));
    check({tag, " dark"}, 32'(dark_cnt), 32'(exp_dark));
    check({tag, " segbad"}, 32'(seg_bad), 32'h0);
  endtask

  int   v0, e0;
  logic ok;
  logic found;

  initial begin
    reset = 1'b1;
    spi.spi_clk = 1'b0;
    spi.spi_din = 1'b0;
    spi.spi_load = 1'b0;
    dout_hist = '0;
    repeat (5) @(negedge clk);
    check_reset_outputs("init");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // intensity 5, shutdown off: 11 of 32 phases lit on digit 0
    send_frame(16'h0A05);
    check("f1 count", 32'(n_valid), 32'd1);
    check("f1 addr", 32'(frame_addr), 32'hA);
    check("f1 data", 32'(frame_data), 32'h05);
    send_frame(16'h0C01);
    check("f2 count", 32'(n_valid), 32'd2);
    check("f2 addr", 32'(frame_addr), 32'hC);
    check("f2 data", 32'(frame_data), 32'h01);
    repeat (100) @(negedge clk);
    exp_lit = '{22, 0, 0, 0, 0, 0};
    exp_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    check_window("int5", 64, 42);

    // decoded '3' on digit 0, raw 0x88 on digit 1
    send_frame(16'h0901);
    send_frame(16'h0103);
    send_frame(16'h0288);
    send_frame(16'h0B01);
    send_frame(16'h0C01);
    check("t2 count", 32'(n_valid), 32'd7);
    repeat (100) @(negedge clk);
    exp_lit = '{22, 22, 0, 0, 0, 0};
    exp_seg = '{7'b0110000, 7'b1110111, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    check_window("dec", 128, 84);

    // short frame, then an over-long frame
    v0 = n_valid;
    e0 = n_err;
    send_bits(32'hFFF, 12);
    pulse_load();
    check("short err", 32'(n_err), 32'(e0 + 1));
    check("short valid", 32'(n_valid), 32'(v0));
    check("short addr", 32'(frame_addr), 32'hC);
    check("short data", 32'(frame_data), 32'h01);
    dout_hist = '0;
    send_bits(32'hC30107, 24);
    check("long dout", 32'(dout_hist[7:0]), 32'hC3);
    pulse_load();
    check("long valid", 32'(n_valid), 32'(v0 + 1));
    check("long err", 32'(n_err), 32'(e0 + 1));
    check("long addr", 32'(frame_addr), 32'h1);
    check("long data", 32'(frame_data), 32'h07);
    repeat (100) @(negedge clk);
    exp_seg[0] = 7'b1111000;
    check_window("long", 128, 84);

    // display test overrides shutdown, then returns to blank
    send_frame(16'h0C00);
    send_frame(16'h0F01);
    repeat (100) @(negedge clk);
    exp_lit = '{62, 62, 62, 62, 62, 62};
    exp_seg = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_window("test", 512, 140);
    send_frame(16'h0F00);
    repeat (100) @(negedge clk);
    exp_lit = '{0, 0, 0, 0, 0, 0};
    check_window("blank", 512, 512);

    // scan limit 7 with 6 physical digits: slots 6 and 7 dark
    send_frame(16'h0C01);
    send_frame(16'h0B07);
    repeat (100) @(negedge clk);
    exp_lit = '{22, 22, 22, 22, 22, 22};
    exp_seg = '{7'b1111000, 7'b1110111, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    check_window("lim7", 512, 380);

    // lower limit to 2 while scanning index 5: next slot is index 0
    v0 = n_valid;
    send_bits(32'h0B02, 16);
    wait_dig(5, 1'b1, 600, ok);
    check("idx5 off", 32'(ok), 32'h1);
    wait_dig(5, 1'b0, 600, ok);
    check("idx5 on", 32'(ok), 32'h1);
    spi.spi_load = 1'b1;
    wait_dig(5, 1'b1, 64, ok);
    check("idx5 end", 32'(ok), 32'h1);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (dig_n !== '1) found = 1'b1;
    end
    check("next lit", 32'(found), 32'h1);
    check("next idx0", 32'(dig_n), 32'h3E);
    spi.spi_load = 1'b0;
    repeat (4) @(negedge clk);
    check("lim2 valid", 32'(n_valid), 32'(v0 + 1));
    repeat (200) @(negedge clk);
    exp_lit = '{22, 22, 22, 0, 0, 0};
    check_window("lim2", 192, 126);

    // reset mid-frame discards the partial frame
    send_bits(32'h1FF, 9);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    v0 = n_valid;
    e0 = n_err;
    send_bits(32'h7F, 7);
    pulse_load();
    check("rst part err", 32'(n_err), 32'(e0 + 1));
    check("rst part valid", 32'(n_valid), 32'(v0));
    send_frame(16'h0A0F);
    check("rst full valid", 32'(n_valid), 32'(v0 + 1));
    check("rst full addr", 32'(frame_addr), 32'hA);
    check("rst full data", 32'(frame_data), 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
